// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the I/D memory port arbiter.
// Optional statistics counters are enabled with the ARB_STATS_EN macro.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_BUSY = 2'b01,
    ARB_DONE = 2'b10
  } arb_state_t;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_I = 1'b1
  } arb_owner_t;

  localparam int STREAK_W = 4;
  localparam logic [STREAK_W-1:0] STREAK_ZERO = {STREAK_W{1'b0}};
  localparam logic [STREAK_W-1:0] STREAK_ONE  = {{(STREAK_W-1){1'b0}}, 1'b1};

  function automatic logic [STREAK_W-1:0] streak_sat_inc(
    input logic [STREAK_W-1:0] cur,
    input logic [STREAK_W-1:0] lim
  );
    logic [STREAK_W-1:0] res;
    if (cur >= lim) begin
      res = lim;
    end else begin
      res = cur + STREAK_ONE;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the data-requester, fetch-requester and SRAM-controller buses of the arbiter.
// slave is the arbiter's view; master is the surrounding pipeline and controller.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;

  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ready;

  modport slave (
    input  d_req, d_we, d_addr, d_wdata, i_req, i_addr, m_rdata, m_ready,
    output d_rdata, d_ready, i_rdata, i_ready, m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output d_req, d_we, d_addr, d_wdata, i_req, i_addr, m_rdata, m_ready,
    input  d_rdata, d_ready, i_rdata, i_ready, m_req, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational pick rule: D has priority until its streak over a waiting I
// reaches MAX_D_STREAK, at which point I is forced through.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic                d_req,
  input  logic                i_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_valid,
  output arb_owner_t          grant_owner,
  output logic [STREAK_W-1:0] streak_next
);

  localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(MAX_D_STREAK);

  logic force_i_s;

  assign force_i_s = i_req && (streak >= STREAK_LIM);

  // Winner selection and the streak value to commit if this grant is taken.
  always_comb begin
    grant_valid = d_req | i_req;
    grant_owner = OWN_D;
    streak_next = streak;
    if (d_req && !force_i_s) begin
      grant_owner = OWN_D;
      if (i_req) begin
        streak_next = streak_sat_inc(streak, STREAK_LIM);
      end else begin
        streak_next = STREAK_ZERO;
      end
    end else if (i_req) begin
      grant_owner = OWN_I;
      streak_next = STREAK_ZERO;
    end else begin
      grant_owner = OWN_D;
      streak_next = streak;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM controller port between fetch (I) and data (D), one transaction at a time.
// Define ARB_STATS_EN to add the grant/conflict statistics outputs.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]        d_grant_cnt,
  output logic [31:0]        i_grant_cnt,
  output logic [31:0]        conflict_cnt
`endif
);

  localparam logic [1:0] ST_IDLE = ARB_IDLE;
  localparam logic [1:0] ST_BUSY = ARB_BUSY;
  localparam logic [1:0] ST_DONE = ARB_DONE;

  logic [1:0]          state_r;
  logic [STREAK_W-1:0] streak_r;
  arb_owner_t          owner_r;

  logic                m_req_r;
  logic                m_we_r;
  logic [AW-1:0]       m_addr_r;
  logic [DW-1:0]       m_wdata_r;
  logic [DW-1:0]       d_rdata_r;
  logic                d_ready_r;
  logic [DW-1:0]       i_rdata_r;
  logic                i_ready_r;

  logic                grant_valid_s;
  arb_owner_t          grant_owner_s;
  logic [STREAK_W-1:0] streak_next_s;
  logic                grant_fire_s;

  arb_pick #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_pick (
    .d_req       (bus.d_req),
    .i_req       (bus.i_req),
    .streak      (streak_r),
    .grant_valid (grant_valid_s),
    .grant_owner (grant_owner_s),
    .streak_next (streak_next_s)
  );

  assign grant_fire_s = (state_r == ST_IDLE) && grant_valid_s;

  assign bus.m_req   = m_req_r;
  assign bus.m_we    = m_we_r;
  assign bus.m_addr  = m_addr_r;
  assign bus.m_wdata = m_wdata_r;
  assign bus.d_rdata = d_rdata_r;
  assign bus.d_ready = d_ready_r;
  assign bus.i_rdata = i_rdata_r;
  assign bus.i_ready = i_ready_r;

  // Arbitration FSM owning the SRAM command registers and requester responses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      streak_r  <= STREAK_ZERO;
      owner_r   <= OWN_D;
      m_req_r   <= 1'b0;
      m_we_r    <= 1'b0;
      m_addr_r  <= {AW{1'b0}};
      m_wdata_r <= {DW{1'b0}};
      d_rdata_r <= {DW{1'b0}};
      d_ready_r <= 1'b0;
      i_rdata_r <= {DW{1'b0}};
      i_ready_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_valid_s) begin
            owner_r  <= grant_owner_s;
            streak_r <= streak_next_s;
            m_req_r  <= 1'b1;
            state_r  <= ST_BUSY;
            if (grant_owner_s == OWN_I) begin
              m_we_r    <= 1'b0;
              m_addr_r  <= bus.i_addr;
              m_wdata_r <= {DW{1'b0}};
            end else begin
              m_we_r    <= bus.d_we;
              m_addr_r  <= bus.d_addr;
              m_wdata_r <= bus.d_wdata;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // Completion is tied to m_ready only, so a requester dropping req mid-access still gets its pulse.
          if (bus.m_ready) begin
            m_req_r <= 1'b0;
            state_r <= ST_DONE;
            if (owner_r == OWN_I) begin
              i_rdata_r <= bus.m_rdata;
              i_ready_r <= 1'b1;
            end else begin
              d_rdata_r <= bus.m_rdata;
              d_ready_r <= 1'b1;
            end
          end else begin
            state_r <= ST_BUSY;
          end
        end
        ST_DONE: begin
          d_ready_r <= 1'b0;
          i_ready_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          m_req_r   <= 1'b0;
          d_ready_r <= 1'b0;
          i_ready_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  // Grant and conflict statistics, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      d_grant_cnt  <= 32'd0;
      i_grant_cnt  <= 32'd0;
      conflict_cnt <= 32'd0;
    end else if (grant_fire_s) begin
      if (grant_owner_s == OWN_I) begin
        i_grant_cnt <= i_grant_cnt + 32'd1;
      end else begin
        d_grant_cnt <= d_grant_cnt + 32'd1;
      end
      if (bus.d_req && bus.i_req) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end else begin
        conflict_cnt <= conflict_cnt;
      end
    end else begin
      d_grant_cnt  <= d_grant_cnt;
      i_grant_cnt  <= i_grant_cnt;
      conflict_cnt <= conflict_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected responses, a negedge
// monitor checks grants against a streak model and pops responses on each ready pulse.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();

`ifdef ARB_STATS_EN
  logic [31:0] d_grant_cnt, i_grant_cnt, conflict_cnt;
  logic [31:0] snap_d, snap_i, snap_c;
  bit          snap_ok = 1'b0;
`endif

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(MAXS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ARB_STATS_EN
    ,
    .d_grant_cnt  (d_grant_cnt),
    .i_grant_cnt  (i_grant_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cmp_n  = 0;
  int fail_n = 0;

  logic [31:0] d_exp_q[$];
  logic [31:0] i_exp_q[$];
  byte         grant_log[$];
  int          d_pulses = 0;
  int          i_pulses = 0;

  int          fixed_wait = 0;
  bit          ctrl_hang  = 1'b0;
  bit          stray_req  = 1'b0;
  bit          in_txn     = 1'b0;
  int          wait_left  = 0;

  logic [31:0] mem    [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  // SRAM controller model: configurable wait states, optional hang and stray pulses.
  initial begin
    bus.m_ready = 1'b0;
    bus.m_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus.m_ready = 1'b0;
      if (stray_req) begin
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'hBAD0BAD0;
        stray_req   = 1'b0;
      end else if (bus.m_req && !ctrl_hang) begin
        if (!in_txn) begin
          in_txn    = 1'b1;
          wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        end
        if (wait_left == 0) begin
          bus.m_ready = 1'b1;
          if (bus.m_we) begin
            bus.m_rdata       = ~bus.m_wdata;
            mem[bus.m_addr]   = bus.m_wdata;
          end else begin
            bus.m_rdata = mem.exists(bus.m_addr) ? mem[bus.m_addr] : init_val(bus.m_addr);
          end
          in_txn = 1'b0;
        end else begin
          wait_left--;
        end
      end
    end
  end

  // Monitor: reference streak model for grants, command stability, response scoreboard.
  logic        s_d, s_i, s_dwe, prev_mreq, prev_dr, prev_ir;
  logic [31:0] s_daddr, s_dwdata, s_iaddr, c_addr, c_wdata;
  logic        c_we;
  bit          exp_i;
  int          mdl_streak = 0;

  always @(negedge clk) begin
    if (!rst) begin
      mdl_streak = 0;
    end else begin
      if (bus.m_req && !prev_mreq) begin
        check("grant_had_req", {31'b0, s_d | s_i}, 32'd1);
        exp_i = s_i && (!s_d || mdl_streak == MAXS);
        if (exp_i || !s_i) mdl_streak = 0;
        else if (mdl_streak < MAXS) mdl_streak++;
        check("grant_addr",  bus.m_addr,  exp_i ? s_iaddr : s_daddr);
        check("grant_we",    {31'b0, bus.m_we}, exp_i ? 32'd0 : {31'b0, s_dwe});
        check("grant_wdata", bus.m_wdata, exp_i ? 32'd0 : s_dwdata);
        grant_log.push_back(exp_i ? 8'h49 : 8'h44);
        c_addr  = bus.m_addr;
        c_we    = bus.m_we;
        c_wdata = bus.m_wdata;
`ifdef ARB_STATS_EN
        if (grant_log.size() == 10 && !snap_ok) begin
          snap_d  = d_grant_cnt;
          snap_i  = i_grant_cnt;
          snap_c  = conflict_cnt;
          snap_ok = 1'b1;
        end
`endif
      end else if (bus.m_req) begin
        check("busy_addr",  bus.m_addr,  c_addr);
        check("busy_we",    {31'b0, bus.m_we}, {31'b0, c_we});
        check("busy_wdata", bus.m_wdata, c_wdata);
      end
      if (bus.d_ready) begin
        d_pulses++;
        check("d_ready_width", {31'b0, prev_dr}, 32'd0);
        if (d_exp_q.size() == 0) check("d_ready_unexpected", {31'b0, bus.d_ready}, 32'd0);
        else check("d_rdata", bus.d_rdata, d_exp_q.pop_front());
      end
      if (bus.i_ready) begin
        i_pulses++;
        check("i_ready_width", {31'b0, prev_ir}, 32'd0);
        if (i_exp_q.size() == 0) check("i_ready_unexpected", {31'b0, bus.i_ready}, 32'd0);
        else check("i_rdata", bus.i_rdata, i_exp_q.pop_front());
      end
    end
    prev_mreq = bus.m_req;
    prev_dr   = bus.d_ready;
    prev_ir   = bus.i_ready;
    s_d       = bus.d_req;
    s_i       = bus.i_req;
    s_dwe     = bus.d_we;
    s_daddr   = bus.d_addr;
    s_dwdata  = bus.d_wdata;
    s_iaddr   = bus.i_addr;
  end

  // Both requester tasks start and end just after a rising edge.
  task automatic d_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bit ok = 1'b0;
    if (we) begin
      d_exp_q.push_back(~wdata);
      shadow[addr] = wdata;
    end else begin
      d_exp_q.push_back(shadow_rd(addr));
    end
    bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.d_ready) begin ok = 1'b1; break; end
    end
    check("d_done", {31'b0, ok}, 32'd1);
    @(posedge clk); #1;
    bus.d_req = 1'b0; bus.d_we = 1'b0;
  endtask

  task automatic i_txn(input logic [31:0] addr);
    bit ok = 1'b0;
    i_exp_q.push_back(init_val(addr));
    bus.i_req = 1'b1; bus.i_addr = addr;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.i_ready) begin ok = 1'b1; break; end
    end
    check("i_done", {31'b0, ok}, 32'd1);
    @(posedge clk); #1;
    bus.i_req = 1'b0;
  endtask

  string pat = "DDDDIDDDDI";

  initial begin
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_req",   {31'b0, bus.m_req},   32'd0);
    check("rst_m_we",    {31'b0, bus.m_we},    32'd0);
    check("rst_m_addr",  bus.m_addr,  32'd0);
    check("rst_m_wdata", bus.m_wdata, 32'd0);
    check("rst_d_ready", {31'b0, bus.d_ready}, 32'd0);
    check("rst_i_ready", {31'b0, bus.i_ready}, 32'd0);
    check("rst_d_rdata", bus.d_rdata, 32'd0);
    check("rst_i_rdata", bus.i_rdata, 32'd0);
`ifdef ARB_STATS_EN
    check("rst_d_cnt", d_grant_cnt, 32'd0);
    check("rst_i_cnt", i_grant_cnt, 32'd0);
    check("rst_c_cnt", conflict_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;

    // D read with two wait states.
    fixed_wait = 2;
    d_txn(1'b0, 32'h40, 32'h0);
    check("t1_d_rdata", bus.d_rdata, 32'hDEADBEEF);
    check("t1_d_pulses", d_pulses, 32'd1);
    check("t1_i_pulses", i_pulses, 32'd0);

    // D write.
    fixed_wait = 1;
    d_txn(1'b1, 32'h80, 32'h12345678);
    check("t2_d_pulses", d_pulses, 32'd2);

    // Stray m_ready while idle.
    stray_req = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_d_rdata", bus.d_rdata, ~32'h12345678);
    check("t5_i_rdata", bus.i_rdata, 32'd0);
    check("t5_m_req", {31'b0, bus.m_req}, 32'd0);
    check("t5_d_pulses", d_pulses, 32'd2);
    check("t5_i_pulses", i_pulses, 32'd0);

    // Reset in the middle of an access, then a late m_ready.
    @(posedge clk); #1;
    ctrl_hang = 1'b1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.m_req) break;
    end
    check("t4_granted", {31'b0, bus.m_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; bus.d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("t4_m_req", {31'b0, bus.m_req}, 32'd0);
    check("t4_d_ready", {31'b0, bus.d_ready}, 32'd0);
    check("t4_i_ready", {31'b0, bus.i_ready}, 32'd0);
    check("t4_d_rdata", bus.d_rdata, 32'd0);
    stray_req = 1'b1;
    ctrl_hang = 1'b0;
    repeat (4) @(negedge clk);
    check("t4_m_req_after", {31'b0, bus.m_req}, 32'd0);
    check("t4_d_pulses", d_pulses, 32'd2);
    check("t4_i_pulses", i_pulses, 32'd0);

    // Both requesters held with a 0-wait controller.
    fixed_wait = 0;
    grant_log.delete();
    @(posedge clk); #1;
    fork
      for (int k = 0; k < 9; k++) d_txn(1'b0, 32'(k) * 32'd4, 32'h0);
      for (int k = 0; k < 2; k++) i_txn(32'h1000 + 32'(k) * 32'd4);
    join
    check("t3_log_len", grant_log.size(), 32'd11);
    for (int k = 0; k < 10; k++) check("t3_order", 32'(grant_log[k]), 32'(pat[k]));
`ifdef ARB_STATS_EN
    check("t6_snap", {31'b0, snap_ok}, 32'd1);
    check("t6_d_cnt", snap_d, 32'd8);
    check("t6_i_cnt", snap_i, 32'd2);
    check("t6_c_cnt", snap_c, 32'd10);
`endif

    // Randomized traffic with random wait states.
    fixed_wait = -1;
    fork
      for (int k = 0; k < 60; k++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        d_txn(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) * 32'd4, $urandom);
      end
      for (int k = 0; k < 60; k++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        i_txn(32'h1000 + 32'($urandom_range(0, 31)) * 32'd4);
      end
    join
    repeat (5) @(negedge clk);
    check("end_d_q_empty", d_exp_q.size(), 32'd0);
    check("end_i_q_empty", i_exp_q.size(), 32'd0);
    check("end_d_pulses", d_pulses, 32'd71);
    check("end_i_pulses", i_pulses, 32'd62);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
